// File: rtl/riscv_pma_cfg.sv
// riscv_pma_cfg
// Writer side of the PMA checker configuration. Software writes a shadow
// copy of the region table over a simple request/ack register port. A
// commit copies the whole shadow set into the active set in one edge, and
// only after the memory pipeline reports idle. The checker therefore never
// sees a partially updated table. Per-entry lock bits are set by a commit
// and are cleared only by reset.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   req_i, we_i       access request (held until ack_o), 1 = write
//   idx_i, wdata_i    register index and write data
//   ack_o, err_o      one-cycle completion, access rejected flag
//   rdata_o           read data, valid with ack_o
//   idle_i            memory pipeline has no outstanding access
//   quiesce_o         asks the core to stop issuing memory accesses
//   update_o          one-cycle pulse when the active set changes
//   pma_cfg_o         active cfg per entry
//   pma_adr_o         active address per entry
//   lock_o            active lock bit per entry
module riscv_pma_cfg #(
    parameter int              XLEN     = 64,
    parameter int              PMA_CNT  = 4,
    parameter logic [13:0]     BOOT_CFG = 14'h0,
    parameter logic [XLEN-1:0] BOOT_ADR = {XLEN{1'b0}}
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_i,
    input  logic                           we_i,
    input  logic [7:0]                     idx_i,
    input  logic [XLEN-1:0]                wdata_i,
    output logic                           ack_o,
    output logic                           err_o,
    output logic [XLEN-1:0]                rdata_o,
    input  logic                           idle_i,
    output logic                           quiesce_o,
    output logic                           update_o,
    output logic [PMA_CNT-1:0][13:0]       pma_cfg_o,
    output logic [PMA_CNT-1:0][XLEN-1:0]   pma_adr_o,
    output logic [PMA_CNT-1:0]             lock_o
);

    localparam int         IW       = (PMA_CNT > 1) ? $clog2(PMA_CNT) : 1;
    localparam logic [7:0] CNT_IDX  = 8'(PMA_CNT);
    localparam logic [7:0] CTRL_IDX = 8'(2 * PMA_CNT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                         state_r;
    logic                           ack_r;
    logic                           err_r;
    logic [XLEN-1:0]                rdata_r;
    logic                           quiesce_r;
    logic                           update_r;
    logic [PMA_CNT-1:0][13:0]       cfg_sh_r;
    logic [PMA_CNT-1:0][XLEN-1:0]   adr_sh_r;
    logic [PMA_CNT-1:0]             lock_sh_r;
    logic [PMA_CNT-1:0][13:0]       cfg_act_r;
    logic [PMA_CNT-1:0][XLEN-1:0]   adr_act_r;
    logic [PMA_CNT-1:0]             lock_act_r;

    logic                           sel_cfg_s;
    logic                           sel_adr_s;
    logic                           sel_ctrl_s;
    logic                           sel_bad_s;
    logic [IW-1:0]                  ent_s;
    logic [PMA_CNT-1:0]             tor_lock_s;
    logic                           err_s;
    logic                           acc_s;
    logic [XLEN-1:0]                rd_s;
    logic                           unused_s;

    // Write data bits that no register implements.
    assign unused_s = ^{wdata_i[XLEN-1:16], wdata_i[14]};

    // Address decode: which register class and which entry idx_i selects.
    always_comb begin
        sel_cfg_s  = 1'b0;
        sel_adr_s  = 1'b0;
        sel_ctrl_s = 1'b0;
        sel_bad_s  = 1'b0;
        ent_s      = {IW{1'b0}};
        if (idx_i < CNT_IDX) begin
            sel_cfg_s = 1'b1;
            ent_s     = IW'(idx_i);
        end else if (idx_i < CTRL_IDX) begin
            sel_adr_s = 1'b1;
            ent_s     = IW'(idx_i - CNT_IDX);
        end else if (idx_i == CTRL_IDX) begin
            sel_ctrl_s = 1'b1;
        end else begin
            sel_bad_s = 1'b1;
        end
    end

    // A locked TOR entry also freezes the address of the entry below it,
    // since that address is the base of the locked range.
    always_comb begin
        tor_lock_s = {PMA_CNT{1'b0}};
        for (int i = 0; i < PMA_CNT - 1; i++) begin
            tor_lock_s[i] = lock_act_r[i+1] && (cfg_act_r[i+1][1:0] == 2'b01);
        end
    end

    // Reject decision against the active locks, and the stall rule:
    // writes are only accepted in IDLE, reads are accepted in any state.
    always_comb begin
        err_s = sel_bad_s;
        if (we_i && sel_cfg_s) begin
            err_s = lock_act_r[ent_s];
        end else if (we_i && sel_adr_s) begin
            err_s = lock_act_r[ent_s] || tor_lock_s[ent_s];
        end else begin
            err_s = sel_bad_s;
        end
        acc_s = req_i && !ack_r && (!we_i || (state_r == ST_IDLE));
    end

    // Read mux over the shadow set.
    always_comb begin
        rd_s = {XLEN{1'b0}};
        if (sel_cfg_s) begin
            rd_s = XLEN'({lock_sh_r[ent_s], 1'b0, cfg_sh_r[ent_s]});
        end else if (sel_adr_s) begin
            rd_s = adr_sh_r[ent_s];
        end else if (sel_ctrl_s) begin
            rd_s = XLEN'(state_r == ST_PENDING);
        end else begin
            rd_s = {XLEN{1'b0}};
        end
    end

    // Register port, shadow writes and the commit state machine.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            ack_r        <= 1'b0;
            err_r        <= 1'b0;
            rdata_r      <= {XLEN{1'b0}};
            quiesce_r    <= 1'b0;
            update_r     <= 1'b0;
            cfg_sh_r     <= '0;
            cfg_sh_r[0]  <= BOOT_CFG;
            adr_sh_r     <= '0;
            adr_sh_r[0]  <= BOOT_ADR;
            lock_sh_r    <= {PMA_CNT{1'b0}};
            cfg_act_r    <= '0;
            cfg_act_r[0] <= BOOT_CFG;
            adr_act_r    <= '0;
            adr_act_r[0] <= BOOT_ADR;
            lock_act_r   <= {PMA_CNT{1'b0}};
        end else begin
            ack_r    <= acc_s;
            err_r    <= acc_s && err_s;
            rdata_r  <= (acc_s && !we_i && !err_s) ? rd_s : {XLEN{1'b0}};
            update_r <= 1'b0;

            if (acc_s && we_i && !err_s) begin
                if (sel_cfg_s) begin
                    cfg_sh_r[ent_s]  <= wdata_i[13:0];
                    lock_sh_r[ent_s] <= wdata_i[15];
                end else if (sel_adr_s) begin
                    adr_sh_r[ent_s] <= wdata_i;
                end else begin
                    // CTRL writes only affect the state machine below.
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (acc_s && we_i && sel_ctrl_s && wdata_i[0]) begin
                        state_r   <= ST_PENDING;
                        quiesce_r <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (idle_i) begin
                        cfg_act_r  <= cfg_sh_r;
                        adr_act_r  <= adr_sh_r;
                        // Locks are sticky: a commit can set them, never clear them.
                        lock_act_r <= lock_act_r | lock_sh_r;
                        update_r   <= 1'b1;
                        state_r    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_r   <= ST_IDLE;
                    quiesce_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    quiesce_r <= 1'b0;
                end
            endcase
        end
    end

    assign ack_o     = ack_r;
    assign err_o     = err_r;
    assign rdata_o   = rdata_r;
    assign quiesce_o = quiesce_r;
    assign update_o  = update_r;
    assign pma_cfg_o = cfg_act_r;
    assign pma_adr_o = adr_act_r;
    assign lock_o    = lock_act_r;

endmodule

// File: tb/tb_riscv_pma_cfg.sv
// Directed bench for riscv_pma_cfg with PMA_CNT=4, XLEN=64,
// BOOT_CFG=14'h0F03, BOOT_ADR=0.
module tb_riscv_pma_cfg;

    logic              clk;
    logic              rst;
    logic              req;
    logic              we;
    logic [7:0]        idx;
    logic [63:0]       wdata;
    logic              ack;
    logic              err;
    logic [63:0]       rdata;
    logic              idle;
    logic              quiesce;
    logic              update;
    logic [3:0][13:0]  pma_cfg;
    logic [3:0][63:0]  pma_adr;
    logic [3:0]        lock;

    int pass_cnt = 0;
    int total_cnt = 0;
    int upd_cnt = 0;

    logic        a_err;
    logic [63:0] a_rdata;
    int          a_cyc;

    riscv_pma_cfg #(
        .XLEN(64), .PMA_CNT(4), .BOOT_CFG(14'h0F03), .BOOT_ADR(64'h0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .idx_i(idx),
        .wdata_i(wdata), .ack_o(ack), .err_o(err), .rdata_o(rdata),
        .idle_i(idle), .quiesce_o(quiesce), .update_o(update),
        .pma_cfg_o(pma_cfg), .pma_adr_o(pma_adr), .lock_o(lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count update pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (update) upd_cnt <= upd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One register access; waits at most 20 cycles for ack.
    task automatic access(input string tag, input logic w, input logic [7:0] i,
                          input logic [63:0] d);
        logic got;
        got   = 1'b0;
        a_cyc = 0;
        req   = 1'b1;
        we    = w;
        idx   = i;
        wdata = d;
        while (!got && a_cyc < 20) begin
            @(posedge clk);
            #1;
            a_cyc++;
            if (ack) got = 1'b1;
        end
        a_err   = err;
        a_rdata = rdata;
        req     = 1'b0;
        we      = 1'b0;
        chk({tag, "_ack"}, 64'(got), 64'd1);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; idx = 8'd0; wdata = 64'd0; idle = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_cfg0", 64'(pma_cfg[0]), 64'h0F03);
        chk("rst_cfg1", 64'(pma_cfg[1]), 64'h0);
        chk("rst_cfg3", 64'(pma_cfg[3]), 64'h0);
        chk("rst_lock", 64'(lock), 64'h0);
        chk("rst_quiesce", 64'(quiesce), 64'h0);
        chk("rst_ack", 64'(ack), 64'h0);

        // Write shadow, commit while pipeline busy
        idle = 1'b0;
        access("wr_adr1", 1'b1, 8'd5, 64'h2000_0000);
        chk("wr_adr1_err", 64'(a_err), 64'd0);
        access("wr_cfg1", 1'b1, 8'd1, 64'h0703);
        chk("wr_cfg1_err", 64'(a_err), 64'd0);
        access("rd_cfg1", 1'b0, 8'd1, 64'd0);
        chk("rd_cfg1_data", a_rdata, 64'h0703);
        access("rd_adr1", 1'b0, 8'd5, 64'd0);
        chk("rd_adr1_data", a_rdata, 64'h2000_0000);
        access("commit1", 1'b1, 8'd8, 64'd1);
        chk("commit1_quiesce", 64'(quiesce), 64'd1);
        chk("commit1_adr1_old", pma_adr[1], 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("pend_quiesce", 64'(quiesce), 64'd1);
        chk("pend_update", 64'(update), 64'd0);
        chk("pend_adr1", pma_adr[1], 64'd0);
        chk("pend_cfg1", 64'(pma_cfg[1]), 64'd0);
        access("rd_ctrl_pend", 1'b0, 8'd8, 64'd0);
        chk("rd_ctrl_pend_data", a_rdata, 64'd1);
        idle = 1'b1;
        @(posedge clk); #1;
        chk("upd_pulse", 64'(update), 64'd1);
        chk("upd_cfg1", 64'(pma_cfg[1]), 64'h0703);
        chk("upd_adr1", pma_adr[1], 64'h2000_0000);
        @(posedge clk); #1;
        chk("upd_drop", 64'(update), 64'd0);
        chk("idle_quiesce", 64'(quiesce), 64'd0);
        chk("upd_cnt1", 64'(upd_cnt), 64'd1);

        // Lock TOR entry 2 and check the write stall around the commit
        access("wr_cfg2", 1'b1, 8'd2, 64'h8001);
        chk("wr_cfg2_err", 64'(a_err), 64'd0);
        access("commit2", 1'b1, 8'd8, 64'd1);
        access("stall_cfg0", 1'b1, 8'd0, 64'h0F03);
        chk("stall_cycles", 64'(a_cyc), 64'd3);
        chk("stall_err", 64'(a_err), 64'd0);
        chk("lock_set", 64'(lock), 64'h4);
        chk("lock_cfg2", 64'(pma_cfg[2]), 64'h0001);
        chk("upd_cnt2", 64'(upd_cnt), 64'd2);
        access("wr_adr2_locked", 1'b1, 8'd6, 64'h3000_0000);
        chk("wr_adr2_err", 64'(a_err), 64'd1);
        access("wr_adr1_tor", 1'b1, 8'd5, 64'h1000_0000);
        chk("wr_adr1_tor_err", 64'(a_err), 64'd1);
        access("wr_cfg3", 1'b1, 8'd3, 64'h0003);
        chk("wr_cfg3_err", 64'(a_err), 64'd0);
        access("wr_cfg2_locked", 1'b1, 8'd2, 64'h0000);
        chk("wr_cfg2_err2", 64'(a_err), 64'd1);
        access("rd_cfg2", 1'b0, 8'd2, 64'd0);
        chk("rd_cfg2_data", a_rdata, 64'h8001);
        access("rd_adr1_kept", 1'b0, 8'd5, 64'd0);
        chk("rd_adr1_kept_data", a_rdata, 64'h2000_0000);

        // Bad index and idle CTRL read
        access("rd_bad", 1'b0, 8'd9, 64'd0);
        chk("rd_bad_err", 64'(a_err), 64'd1);
        chk("rd_bad_data", a_rdata, 64'd0);
        access("rd_ctrl_idle", 1'b0, 8'd8, 64'd0);
        chk("rd_ctrl_idle_err", 64'(a_err), 64'd0);
        chk("rd_ctrl_idle_data", a_rdata, 64'd0);

        // Reset in the middle of a commit
        idle = 1'b0;
        access("wr_cfg1_b", 1'b1, 8'd1, 64'h0005);
        access("commit3", 1'b1, 8'd8, 64'd1);
        chk("commit3_quiesce", 64'(quiesce), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_quiesce", 64'(quiesce), 64'd0);
        chk("mid_rst_cfg1", 64'(pma_cfg[1]), 64'd0);
        chk("mid_rst_lock", 64'(lock), 64'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        idle = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_upd_cnt", 64'(upd_cnt), 64'd2);
        chk("post_rst_cfg0", 64'(pma_cfg[0]), 64'h0F03);
        chk("post_rst_cfg1", 64'(pma_cfg[1]), 64'd0);
        access("rd_cfg1_rst", 1'b0, 8'd1, 64'd0);
        chk("rd_cfg1_rst_data", a_rdata, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
